// File: rtl/ctrl_word_executor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_word_executor: 4-cycle control-word ALU with a 16x16 register file   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ctrl_word_executor #(
  parameter int IMM_SEXT = 0
) (
  input  logic        external_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [16:0] cmd_word,
  output logic [15:0] result,
  output logic        result_valid,
  output logic [4:0]  flags,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] word_q;
  logic [15:0] a_q, b_q, result_q;
  logic [4:0]  flags_q;
  logic        cmd_ready_q, result_valid_q, wb_en_q;
  logic [15:0] regs_q [16];

  logic [15:0] imm_ext;
  logic [16:0] sum;
  logic [15:0] diff;
  logic [15:0] alu_res;
  logic        alu_c, alu_l, alu_f, alu_upd, alu_wr;

  always_comb begin
    if (IMM_SEXT != 0) imm_ext = {{8{word_q[11]}}, word_q[11:4]};
    else               imm_ext = {8'h00, word_q[11:4]};
  end

  always_ff @(posedge external_clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = a_q - b_q;

  always_comb begin
    alu_res = a_q;
    alu_c   = 1'b0;
    alu_l   = 1'b0;
    alu_f   = 1'b0;
    alu_upd = 1'b1;
    alu_wr  = 1'b1;
    case (word_q[15:12])
      4'h0: alu_res = a_q & b_q;
      4'h1: alu_res = a_q | b_q;
      4'h2: begin
        alu_res = sum[15:0];
        alu_c   = sum[16];
        alu_f   = (a_q[15] == b_q[15]) && (sum[15] != a_q[15]);
      end
      4'h3, 4'h8: begin
        // CMP shares the subtractor but never writes back
        alu_res = diff;
        alu_c   = (a_q >= b_q);
        alu_l   = (a_q < b_q);
        alu_f   = (a_q[15] != b_q[15]) && (diff[15] != a_q[15]);
        alu_wr  = (word_q[15:12] == 4'h3);
      end
      4'h4: alu_res = a_q ^ b_q;
      4'h5: alu_res = ~a_q;
      4'h6: begin
        alu_res = {a_q[14:0], 1'b0};
        alu_c   = a_q[15];
      end
      4'h7: begin
        alu_res = {1'b0, a_q[15:1]};
        alu_c   = a_q[0];
      end
      4'h9: alu_res = b_q;
      default: begin
        alu_upd = 1'b0;
        alu_wr  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge external_clk) begin
    if (!reset) begin
      word_q         <= '0;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      flags_q        <= '0;
      wb_en_q        <= 1'b0;
      cmd_ready_q    <= 1'b1;
      result_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      cmd_ready_q    <= (state_d == IDLE);
      result_valid_q <= (state_d == WB);
      case (state_q)
        IDLE: if (cmd_valid) word_q <= cmd_word;
        READ: begin
          if (word_q[16]) begin
            a_q <= regs_q[word_q[3:0]];
            b_q <= imm_ext;
          end else begin
            a_q <= regs_q[word_q[11:8]];
            b_q <= regs_q[word_q[7:4]];
          end
        end
        EXEC: begin
          result_q <= alu_res;
          if (alu_upd) flags_q <= {alu_c, alu_l, alu_f, (alu_res == 16'h0000), alu_res[15]};
          wb_en_q  <= alu_wr;
        end
        WB: if (wb_en_q) regs_q[word_q[3:0]] <= result_q;
        default: ;
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign flags        = flags_q;
  assign dbg_data     = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_ctrl_word_executor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ctrl_word_executor: zero- and sign-extending instances vs. a model     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_ctrl_word_executor;

  logic        external_clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [16:0] cmd_word;
  logic [3:0]  dbg_addr;
  logic [1:0]  rdy, rv;
  logic [15:0] res [2];
  logic [15:0] dbg [2];
  logic [4:0]  fl  [2];

  int tot  = 0;
  int pass = 0;
  bit checking = 1'b0;

  always #5 external_clk = ~external_clk;

  ctrl_word_executor #(.IMM_SEXT(0)) u_dut0 (
    .external_clk(external_clk), .reset(reset), .cmd_valid(cmd_valid),
    .cmd_ready(rdy[0]), .cmd_word(cmd_word), .result(res[0]),
    .result_valid(rv[0]), .flags(fl[0]), .dbg_addr(dbg_addr), .dbg_data(dbg[0])
  );

  ctrl_word_executor #(.IMM_SEXT(1)) u_dut1 (
    .external_clk(external_clk), .reset(reset), .cmd_valid(cmd_valid),
    .cmd_ready(rdy[1]), .cmd_word(cmd_word), .result(res[1]),
    .result_valid(rv[1]), .flags(fl[1]), .dbg_addr(dbg_addr), .dbg_data(dbg[1])
  );

  // Reference: index 0 zero-extends the immediate, index 1 sign-extends it.
  logic [15:0] mreg [2][16];
  logic [15:0] mres [2];
  logic [4:0]  mfl  [2];
  logic [15:0] p_res [2];
  logic [4:0]  p_fl  [2];
  bit          p_upd [2];
  bit          p_wr  [2];
  logic [3:0]  p_rd;
  int          busy = 0;

  function automatic int to_signed(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic void model_op(input logic [16:0] w, input int k,
                                   output logic [15:0] r, output logic [4:0] f5,
                                   output bit upd, output bit wr);
    int unsigned a, b, t;
    int          s;
    logic [7:0]  imm;
    bit          c, l, f;
    imm = w[11:4];
    if (w[16]) begin
      a = mreg[k][w[3:0]];
      b = (k == 1 && imm[7]) ? (32'(imm) | 32'hFF00) : 32'(imm);
    end else begin
      a = mreg[k][w[11:8]];
      b = mreg[k][w[7:4]];
    end
    c = 0; l = 0; f = 0; upd = 1; wr = 1;
    case (w[15:12])
      4'd0: t = a & b;
      4'd1: t = a | b;
      4'd2: begin
        t = a + b;
        c = (t > 65535);
        s = to_signed(a) + to_signed(b);
        f = (s > 32767) || (s < -32768);
      end
      4'd3, 4'd8: begin
        t = a - b;
        c = (a >= b);
        l = (a < b);
        s = to_signed(a) - to_signed(b);
        f = (s > 32767) || (s < -32768);
        wr = (w[15:12] == 4'd3);
      end
      4'd4: t = a ^ b;
      4'd5: t = 65535 - a;
      4'd6: begin t = a * 2; c = (a >= 32768); end
      4'd7: begin t = a / 2; c = (a % 2) == 1; end
      4'd9: t = b;
      default: begin t = a; upd = 0; wr = 0; end
    endcase
    r  = 16'(t & 32'hFFFF);
    f5 = {c, l, f, (r == 16'h0000), r[15]};
  endfunction

  always @(posedge external_clk) begin
    if (!reset) begin
      busy = 0;
      for (int k = 0; k < 2; k++) begin
        mres[k] = '0;
        mfl[k]  = '0;
        for (int i = 0; i < 16; i++) mreg[k][i] = '0;
      end
    end else if (busy > 0) begin
      busy = busy - 1;
      if (busy == 1)
        for (int k = 0; k < 2; k++) begin
          mres[k] = p_res[k];
          if (p_upd[k]) mfl[k] = p_fl[k];
        end
      if (busy == 0)
        for (int k = 0; k < 2; k++)
          if (p_wr[k]) mreg[k][p_rd] = p_res[k];
    end else if (cmd_valid) begin
      for (int k = 0; k < 2; k++)
        model_op(cmd_word, k, p_res[k], p_fl[k], p_upd[k], p_wr[k]);
      p_rd = cmd_word[3:0];
      busy = 3;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge external_clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ready%0d", k),  32'(rdy[k]), 32'(busy == 0));
        chk($sformatf("rvalid%0d", k), 32'(rv[k]),  32'(busy == 1));
        chk($sformatf("result%0d", k), 32'(res[k]), 32'(mres[k]));
        chk($sformatf("flags%0d", k),  32'(fl[k]),  32'(mfl[k]));
        chk($sformatf("dbg%0d", k),    32'(dbg[k]), 32'(mreg[k][dbg_addr]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge external_clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1);
    reset = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rdy[0] && n < 20) begin
      step(1);
      n++;
    end
    if (n >= 20) begin
      tot++;
      $display("FAIL accept_timeout: cmd_ready stayed %b, expected 1", rdy[0]);
    end
  endtask

  // Returns 2 time units after the accepting edge.
  task automatic send(input logic [16:0] w);
    cmd_word  = w;
    cmd_valid = 1'b1;
    wait_ready();
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic peek(input string name, input logic [3:0] addr,
                      input logic [15:0] e0, input logic [15:0] e1);
    dbg_addr = addr;
    #1;
    chk({name, "_z"}, 32'(dbg[0]), 32'(e0));
    chk({name, "_s"}, 32'(dbg[1]), 32'(e1));
  endtask

  logic [9:0] rpat;
  int         pulses;

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_word = '0; dbg_addr = '0;
    step(2);
    chk("rst_ready", 32'(rdy[0]), 32'h1);
    chk("rst_result", 32'(res[0]), 32'h0);
    chk("rst_flags", 32'(fl[0]), 32'h0);
    reset = 1'b1;
    checking = 1'b1;

    send(17'b1_0010_1110_0001_1111);
    step(1);
    chk("imm_exec_rv", 32'(rv[0]), 32'h0);
    step(1);
    chk("imm_wb_rv", 32'(rv[0]), 32'h1);
    chk("imm_res_z", 32'(res[0]), 32'h00E1);
    chk("imm_res_s", 32'(res[1]), 32'hFFE1);
    chk("imm_flags_z", 32'(fl[0]), 32'h00);
    chk("imm_flags_s", 32'(fl[1]), 32'h01);
    step(1);
    peek("imm_r15", 4'd15, 16'h00E1, 16'hFFE1);

    send(17'b0_0010_1111_1110_0000);
    step(2);
    chk("add_flags_z", 32'(fl[0]), 32'h00);
    step(1);
    peek("add_r0", 4'd0, 16'h00E1, 16'hFFE1);

    do_reset();
    send(17'b1_0010_0000_0001_0001);
    step(3);
    send(17'b0_0011_0010_0001_0011);
    step(2);
    chk("sub_res", 32'(res[0]), 32'hFFFF);
    chk("sub_flags", 32'(fl[0]), 32'b01001);
    step(1);
    peek("sub_r3", 4'd3, 16'hFFFF, 16'hFFFF);
    send(17'b1_0010_0000_0001_0011);
    step(2);
    chk("wrap_res", 32'(res[0]), 32'h0000);
    chk("wrap_flags", 32'(fl[0]), 32'b10010);
    step(1);
    peek("wrap_r3", 4'd3, 16'h0000, 16'h0000);

    cmd_word  = 17'b1_1001_0101_0101_0110;
    cmd_valid = 1'b1;
    wait_ready();
    step(1);
    cmd_word = 17'b1_0010_0000_0011_0110;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      rpat[i] = rdy[0];
      pulses += int'(rv[0]);
      if (i == 4) cmd_valid = 1'b0;
      if (i < 9) step(1);
    end
    chk("hold_ready_pattern", 32'(rpat), 32'(10'b1110001000));
    chk("hold_pulses", 32'(pulses), 32'd2);
    peek("hold_r6", 4'd6, 16'h0058, 16'h0058);

    send(17'b1_0010_0001_0010_0101);
    step(1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("abort_rv", 32'(rv[0]), 32'h0);
    chk("abort_ready", 32'(rdy[0]), 32'h1);
    step(1);
    chk("abort_rv_late", 32'(rv[0]), 32'h0);
    peek("abort_r5", 4'd5, 16'h0000, 16'h0000);

    for (int c = 0; c < 1500; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_word  = 17'($urandom);
      dbg_addr  = 4'($urandom);
      reset     = ($urandom_range(0, 59) != 0);
      step(1);
    end
    reset = 1'b1;
    cmd_valid = 1'b0;
    step(5);

    checking = 1'b0;
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_word_executor.md
CTRL_WORD_EXECUTOR -- requirements
Module: ctrl_word_executor

Interface
REQ-001 Parameter IMM_SEXT, default 0: 1 = sign-extend the 8-bit immediate to 16 bits; 0 = zero-extend it.
REQ-002 external_clk  in  1   clock; all state changes on its rising edge.
REQ-003 reset  in  1   reset, synchronous, active-low.
REQ-004 cmd_valid  in  1   control word offered.
REQ-005 cmd_ready  out  1   block can accept a word.
REQ-006 cmd_word  in  17   control word, fields below.
REQ-007 result  out  16   last ALU result.
REQ-008 result_valid  out  1   one-cycle pulse marking a new result.
REQ-009 flags  out  5   {C,L,F,Z,N}, bits [4:0].
REQ-010 dbg_addr  in  4   register-file debug read address.
REQ-011 dbg_data  out  16   combinational read of reg[dbg_addr].

Function
REQ-012 Word fields SHALL be: [16] imm_sel, [15:12] op, [11:8] ra, [7:4] rb, [3:0] rd.
REQ-013 Operands for imm_sel=0 SHALL be A=reg[ra], B=reg[rb], destination rd.
REQ-014 Operands for imm_sel=1 SHALL be A=reg[rd], B=extend([11:4]) per IMM_SEXT, destination rd.
REQ-015 Register file SHALL be 16 x 16 bits, with one write port and two operand read ports plus the debug port.
REQ-016 Opcodes SHALL be:
- 0000 AND; 0001 OR; 0010 ADD; 0011 SUB (A-B); 0100 XOR; 0101 NOT A
- 0110 SHL A by 1; 0111 SHR A by 1 (logical); 1000 CMP (SUB, no writeback); 1001 MOV (B)
REQ-017 Opcodes 1010-1111 SHALL produce result=A, with no writeback and flags unchanged.
REQ-018 Arithmetic SHALL be modulo 2^16.
REQ-019 Z SHALL be (result==0) and N SHALL be result[15] for every defined op.
REQ-020 C SHALL be: ADD carry-out; SUB/CMP 1 when A>=B unsigned; SHL old A[15]; SHR old A[0]; 0 for other ops.
REQ-021 L SHALL be (A<B unsigned) for SUB/CMP and 0 for other ops.
REQ-022 F SHALL be signed overflow for ADD/SUB/CMP and 0 for other ops.
REQ-023 FSM states SHALL be IDLE -> READ -> EXEC -> WB -> IDLE, with one cycle per state.
REQ-024 cmd_ready SHALL equal (state==IDLE), registered.
REQ-025 A word SHALL be captured at an edge where cmd_valid and cmd_ready are both 1; that edge is N.
REQ-026 Edges N+1, N+2 and N+3 SHALL enter EXEC, WB and IDLE respectively.
REQ-027 READ SHALL latch operands; EXEC SHALL latch result and flags.
REQ-028 result_valid SHALL be 1 exactly during WB (edge N+2 to edge N+3).
REQ-029 The register write SHALL occur at edge N+3.
REQ-030 result and flags SHALL hold until the next EXEC.
REQ-031 cmd_valid outside IDLE SHALL be ignored; cmd_word need only be stable at the accept edge.
REQ-032 Earliest next accept SHALL be edge N+4, giving throughput of one word per 4 cycles.
REQ-033 The next word SHALL read the written value, so no hazard is possible.
REQ-034 rd==ra or rd==rb SHALL be legal, with operands being pre-write values.

Reset
REQ-035 reset=0 at an edge SHALL force: state IDLE, cmd_ready 1, result 0x0000, result_valid 0, flags 00000, all registers 0x0000.
REQ-036 Reset at any FSM state SHALL abort the operation with no writeback and no result_valid pulse.
REQ-037 Reset SHALL dominate a simultaneous cmd_valid, and the word SHALL NOT be accepted.

Verification
REQ-038 Reset, then 1_0010_1110_0001_1111 (IMM_SEXT=0) -> result 0x00E1 valid at N+2; flags 00000; dbg r15=0x00E1 after N+3.
REQ-039 Then 0_0010_1111_1110_0000 -> r0 = r15 + r14 = 0x00E1; Z=0, C=0.
REQ-040 From reset:
- load r1=0x0001 with 1_0010_0000_0001_0001
- then 0_0011_0010_0001_0011 (r3 = r2 - r1) -> r3=0xFFFF, flags C=0, L=1, F=0, Z=0, N=1
REQ-041 Then 1_0010_0000_0001_0011 (r3 = r3 + 1) -> r3=0x0000, flags C=1, Z=1, N=0, F=0.
REQ-042 cmd_valid held high with two words -> accepts at N and N+4 only; cmd_ready low for edges N+1..N+3; exactly two result_valid pulses.
REQ-043 Reset driven low at edge N+2 of an ADD -> no result_valid; target register stays 0x0000; cmd_ready=1 the next cycle.
